fft_butterfly_pipe: RTL and testbench
=====================================

Name: fft_butterfly_pipe

Overview:
Parametrised, pipelined radix-2 DIT butterfly for the FFT datapath: f0 = x0 + W·x1, f1 = x0 − W·x1.
It replaces the single-register butterfly with:
- configurable data width, twiddle width and twiddle fraction bits
- rounding
- saturate or wrap overflow handling
- optional per-beat divide-by-2 stage scaling
- valid/ready flow control and an overflow flag
It sits between the stage sample buffers and the twiddle ROM in each FFT stage.

Parameters:
DW, 16, data width of x0/x1/f0/f1 components (two's complement)
TW, 16, twiddle component width (two's complement)
TFRAC, 8, twiddle fraction bits (W = tw/2^TFRAC); must satisfy 1 ≤ TFRAC < TW
ROUND, 1, 1 = round-half-up on the twiddle-product shift and on scaling; 0 = truncate (arithmetic shift)
SAT, 1, 1 = saturate outputs to DW range; 0 = two's-complement wrap (keep low DW bits)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept input this cycle
x0_r, x0_i  in  DW  first operand
x1_r, x1_i  in  DW  second operand
tw_r, tw_i  in  TW  twiddle factor
scale_en  in  1  divide this beat's outputs by 2
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output
f0_r, f0_i, f1_r, f1_i  out  DW  results
out_ovf  out  1  this output beat overflowed DW range before saturate/wrap
ovf_sticky  out  1  sticky overflow flag
clr_ovf  in  1  synchronous clear of ovf_sticky

Behaviour:
- Reset (async, active-high): all pipeline valid bits = 0; outputs out_valid, out_ovf, ovf_sticky, f0_*, f1_* = 0. in_ready = 1 after reset.
- Pipeline: 3 register stages. Global advance enable: en = !out_valid || out_ready. in_ready = en (combinational).
- Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Latency: an accepted beat appears on outputs exactly 3 cycles later when en stays 1. When en = 0, all stages hold; no beat is lost, duplicated or reordered.
- Stage 1: register x0, x1, tw, scale_en and valid.
- Stage 2: four full-precision products p_rr = tw_r·x1_r, p_ii = tw_i·x1_i, p_ri = tw_r·x1_i, p_ir = tw_i·x1_r, each DW+TW bits.
  - t_r = p_rr − p_ii and t_i = p_ri + p_ir, each DW+TW+1 bits.
  - m_r = (t_r + R) >>> TFRAC and m_i likewise, where R = 2^(TFRAC−1) if ROUND else 0.
  - Register m_r, m_i, x0, scale_en and valid.
- Stage 3: a = x0 ± m in full width (DW+TW+2 bits); no truncation before this point.
  - If scale_en: a = (a + (ROUND ? 1 : 0)) >>> 1.
  - Overflow: a component overflows if a > 2^(DW−1)−1 or a < −2^(DW−1). out_ovf = OR over the 4 components.
  - SAT=1: clamp to 2^(DW−1)−1 / −2^(DW−1). SAT=0: low DW bits.
  - Register results, out_ovf and out_valid.
- out_ovf is valid only while out_valid = 1; it is held while stalled.
- ovf_sticky:
  - Sets on the cycle a beat with out_ovf = 1 transfers out.
  - clr_ovf clears it on the next edge.
  - If set and clear occur in the same cycle, set wins.
- scale_en travels with its beat; changing scale_en between beats has no effect on beats already in flight.
- Bubbles (stages with valid = 0) still advance under en; outputs hold the last values while out_valid = 0.
- Reset asserted mid-stream: all in-flight beats are discarded immediately and outputs go to the reset values above.

Test Plan:
All scenarios use DW=16, TW=16, TFRAC=8 unless stated.
1. Identity twiddle: tw=(256,0), x0=(100,50), x1=(20,−10), out_ready=1 -> 3 cycles later f0=(120,40), f1=(80,60), out_ovf=0.
2. Twiddle −j: tw=(0,−256), same x0/x1 -> f0=(90,30), f1=(110,70).
3. Overflow, tw=(256,0), x0_r=30000, x1_r=10000, other components 0:
   - SAT=1 -> f0_r=32767, f1_r=20000, out_ovf=1, ovf_sticky=1 next cycle; clr_ovf pulse -> 0.
   - SAT=0 -> f0_r=−25536.
   - Same beat with scale_en=1 -> f0_r=20000, f1_r=10000, out_ovf=0.
4. Rounding: tw=(128,0), x1_r=3, x0=0 -> ROUND=1: f0_r=2, f1_r=−2. ROUND=0: f0_r=1, f1_r=−1.
5. Backpressure: stream 10 beats with incrementing x0_r, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 while stalled; output sequence complete, in order, no duplicates; ovf_sticky set+clear in same cycle -> stays 1.
6. Reset mid-stream: assert rst with 3 beats in flight -> out_valid=0 and all outputs 0 immediately; after release, first new beat emerges 3 cycles after acceptance.

Source files
------------

// File: rtl/fft_butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly: f0 = x0 + W*x1, f1 = x0 - W*x1.
// Three register stages share one advance enable, so a stall freezes the whole pipe.
module fft_butterfly_pipe #(
    parameter int DW    = 16,
    parameter int TW    = 16,
    parameter int TFRAC = 8,
    parameter int ROUND = 1,
    parameter int SAT   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x0_r,
    input  logic [DW-1:0] x0_i,
    input  logic [DW-1:0] x1_r,
    input  logic [DW-1:0] x1_i,
    input  logic [TW-1:0] tw_r,
    input  logic [TW-1:0] tw_i,
    input  logic          scale_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] f0_r,
    output logic [DW-1:0] f0_i,
    output logic [DW-1:0] f1_r,
    output logic [DW-1:0] f1_i,
    output logic          out_ovf,
    output logic          ovf_sticky,
    input  logic          clr_ovf
);
    localparam int PW  = DW + TW;
    localparam int TWD = PW + 1;
    localparam int AW  = PW + 2;

    localparam logic signed [TWD-1:0] RND_M = (ROUND != 0) ? (TWD'(1) <<< (TFRAC - 1)) : '0;
    localparam logic signed [AW-1:0]  RND_S = (ROUND != 0) ? AW'(1) : '0;
    localparam logic signed [AW-1:0]  MAXV  = AW'((2 ** (DW - 1)) - 1);
    localparam logic signed [AW-1:0]  MINV  = ~MAXV;

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage 1: operand capture
    logic          v1;
    logic [DW-1:0] s1_x0r, s1_x0i, s1_x1r, s1_x1i;
    logic [TW-1:0] s1_twr, s1_twi;
    logic          s1_sc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            s1_x0r <= '0;
            s1_x0i <= '0;
            s1_x1r <= '0;
            s1_x1i <= '0;
            s1_twr <= '0;
            s1_twi <= '0;
            s1_sc  <= 1'b0;
        end else if (en) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_x0r <= x0_r;
                s1_x0i <= x0_i;
                s1_x1r <= x1_r;
                s1_x1i <= x1_i;
                s1_twr <= tw_r;
                s1_twi <= tw_i;
                s1_sc  <= scale_en;
            end
        end
    end

    // Stage 2: complex multiply in full precision, then one rounded shift
    logic signed [PW-1:0]  p_rr, p_ii, p_ri, p_ir;
    logic signed [TWD-1:0] t_r, t_i, m_r, m_i;

    assign p_rr = PW'($signed(s1_twr)) * PW'($signed(s1_x1r));
    assign p_ii = PW'($signed(s1_twi)) * PW'($signed(s1_x1i));
    assign p_ri = PW'($signed(s1_twr)) * PW'($signed(s1_x1i));
    assign p_ir = PW'($signed(s1_twi)) * PW'($signed(s1_x1r));
    assign t_r  = TWD'(p_rr) - TWD'(p_ii);
    assign t_i  = TWD'(p_ri) + TWD'(p_ir);
    assign m_r  = (t_r + RND_M) >>> TFRAC;
    assign m_i  = (t_i + RND_M) >>> TFRAC;

    logic                  v2;
    logic signed [TWD-1:0] s2_mr, s2_mi;
    logic [DW-1:0]         s2_x0r, s2_x0i;
    logic                  s2_sc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2     <= 1'b0;
            s2_mr  <= '0;
            s2_mi  <= '0;
            s2_x0r <= '0;
            s2_x0i <= '0;
            s2_sc  <= 1'b0;
        end else if (en) begin
            v2 <= v1;
            if (v1) begin
                s2_mr  <= m_r;
                s2_mi  <= m_i;
                s2_x0r <= s1_x0r;
                s2_x0i <= s1_x0i;
                s2_sc  <= s1_sc;
            end
        end
    end

    // Stage 3: add/subtract, optional halving, then range reduction; result is {ovf, value}
    function automatic logic [DW:0] reduce(input logic signed [AW-1:0] a, input logic sc);
        logic signed [AW-1:0] s;
        logic                 ovf;
        logic [DW-1:0]        val;
        s   = sc ? ((a + RND_S) >>> 1) : a;
        ovf = (s > MAXV) || (s < MINV);
        val = s[DW-1:0];
        if (SAT != 0 && s > MAXV) val = {1'b0, {(DW-1){1'b1}}};
        if (SAT != 0 && s < MINV) val = {1'b1, {(DW-1){1'b0}}};
        return {ovf, val};
    endfunction

    logic signed [AW-1:0] acc [4];
    logic [DW:0]          res [4];

    assign acc[0] = AW'($signed(s2_x0r)) + AW'(s2_mr);
    assign acc[1] = AW'($signed(s2_x0i)) + AW'(s2_mi);
    assign acc[2] = AW'($signed(s2_x0r)) - AW'(s2_mr);
    assign acc[3] = AW'($signed(s2_x0i)) - AW'(s2_mi);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_reduce
            assign res[gi] = reduce(acc[gi], s2_sc);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
            f0_r      <= '0;
            f0_i      <= '0;
            f1_r      <= '0;
            f1_i      <= '0;
        end else if (en) begin
            out_valid <= v2;
            if (v2) begin
                f0_r    <= res[0][DW-1:0];
                f0_i    <= res[1][DW-1:0];
                f1_r    <= res[2][DW-1:0];
                f1_i    <= res[3][DW-1:0];
                out_ovf <= res[0][DW] | res[1][DW] | res[2][DW] | res[3][DW];
            end
        end
    end

    // A set on the same edge as a clear takes priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_sticky <= 1'b0;
        else if (out_valid && out_ready && out_ovf)
            ovf_sticky <= 1'b1;
        else if (clr_ovf)
            ovf_sticky <= 1'b0;
    end
endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Directed bench: default instance plus wrap (SAT=0) and truncate (ROUND=0) variants on shared inputs.
module tb_fft_butterfly_pipe;
    localparam int DW = 16;
    localparam int TW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic scale_en = 1'b0;
    logic clr_ovf = 1'b0;
    logic [DW-1:0] x0_r = '0, x0_i = '0, x1_r = '0, x1_i = '0;
    logic [TW-1:0] tw_r = '0, tw_i = '0;

    logic in_ready, out_valid, out_ovf, ovf_sticky;
    logic [DW-1:0] f0_r, f0_i, f1_r, f1_i;
    logic in_ready_w, out_valid_w, out_ovf_w, ovf_sticky_w;
    logic [DW-1:0] f0_r_w, f0_i_w, f1_r_w, f1_i_w;
    logic in_ready_t, out_valid_t, out_ovf_t, ovf_sticky_t;
    logic [DW-1:0] f0_r_t, f0_i_t, f1_r_t, f1_i_t;

    int vectors = 0;
    int miscompares = 0;
    int sent, got;

    always #5 clk = ~clk;

    fft_butterfly_pipe #(.DW(DW), .TW(TW), .TFRAC(8), .ROUND(1), .SAT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x0_r(x0_r), .x0_i(x0_i), .x1_r(x1_r), .x1_i(x1_i), .tw_r(tw_r), .tw_i(tw_i),
        .scale_en(scale_en), .out_valid(out_valid), .out_ready(out_ready),
        .f0_r(f0_r), .f0_i(f0_i), .f1_r(f1_r), .f1_i(f1_i),
        .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf));

    fft_butterfly_pipe #(.DW(DW), .TW(TW), .TFRAC(8), .ROUND(1), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .x0_r(x0_r), .x0_i(x0_i), .x1_r(x1_r), .x1_i(x1_i), .tw_r(tw_r), .tw_i(tw_i),
        .scale_en(scale_en), .out_valid(out_valid_w), .out_ready(out_ready),
        .f0_r(f0_r_w), .f0_i(f0_i_w), .f1_r(f1_r_w), .f1_i(f1_i_w),
        .out_ovf(out_ovf_w), .ovf_sticky(ovf_sticky_w), .clr_ovf(clr_ovf));

    fft_butterfly_pipe #(.DW(DW), .TW(TW), .TFRAC(8), .ROUND(0), .SAT(1)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
        .x0_r(x0_r), .x0_i(x0_i), .x1_r(x1_r), .x1_i(x1_i), .tw_r(tw_r), .tw_i(tw_i),
        .scale_en(scale_en), .out_valid(out_valid_t), .out_ready(out_ready),
        .f0_r(f0_r_t), .f0_i(f0_i_t), .f1_r(f1_r_t), .f1_i(f1_i_t),
        .out_ovf(out_ovf_t), .ovf_sticky(ovf_sticky_t), .clr_ovf(clr_ovf));

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("vector %0d %s observed %0d expected %0d", vectors, tag, obs, exp);
    endtask

    // One beat in, then wait until it sits on the outputs (third edge after drive)
    task automatic send(input int a_r, input int a_i, input int b_r, input int b_i,
                        input int w_r, input int w_i, input logic sc);
        @(negedge clk);
        in_valid = 1'b1;
        x0_r = 16'(a_r); x0_i = 16'(a_i);
        x1_r = 16'(b_r); x1_i = 16'(b_i);
        tw_r = 16'(w_r); tw_i = 16'(w_i);
        scale_en = sc;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_f0_r", $signed(f0_r), 0);
        chk("rst_sticky", ovf_sticky, 0);
        @(negedge clk);
        rst = 1'b0;

        // Identity twiddle
        send(100, 50, 20, -10, 256, 0, 1'b0);
        chk("id_valid", out_valid, 1);
        chk("id_f0_r", $signed(f0_r), 120);
        chk("id_f0_i", $signed(f0_i), 40);
        chk("id_f1_r", $signed(f1_r), 80);
        chk("id_f1_i", $signed(f1_i), 60);
        chk("id_ovf", out_ovf, 0);

        // Twiddle -j
        send(100, 50, 20, -10, 0, -256, 1'b0);
        chk("mj_f0_r", $signed(f0_r), 90);
        chk("mj_f0_i", $signed(f0_i), 30);
        chk("mj_f1_r", $signed(f1_r), 110);
        chk("mj_f1_i", $signed(f1_i), 70);

        // Overflow: saturate vs wrap, sticky set and clear
        send(30000, 0, 10000, 0, 256, 0, 1'b0);
        chk("ovf_sat_f0_r", $signed(f0_r), 32767);
        chk("ovf_sat_f1_r", $signed(f1_r), 20000);
        chk("ovf_flag", out_ovf, 1);
        chk("ovf_wrap_f0_r", $signed(f0_r_w), -25536);
        chk("ovf_wrap_f1_r", $signed(f1_r_w), 20000);
        chk("ovf_sticky_pre", ovf_sticky, 0);
        @(posedge clk);
        #1;
        chk("ovf_sticky_set", ovf_sticky, 1);
        clr_ovf = 1'b1;
        @(posedge clk);
        #1 clr_ovf = 1'b0;
        chk("ovf_sticky_clr", ovf_sticky, 0);

        // Same beat halved
        send(30000, 0, 10000, 0, 256, 0, 1'b1);
        chk("scale_f0_r", $signed(f0_r), 20000);
        chk("scale_f1_r", $signed(f1_r), 10000);
        chk("scale_ovf", out_ovf, 0);
        chk("scale_wrap_f0_r", $signed(f0_r_w), 20000);

        // Rounding vs truncation of the product shift
        send(0, 0, 3, 0, 128, 0, 1'b0);
        chk("rnd_f0_r", $signed(f0_r), 2);
        chk("rnd_f1_r", $signed(f1_r), -2);
        chk("trunc_f0_r", $signed(f0_r_t), 1);
        chk("trunc_f1_r", $signed(f1_r_t), -1);
        @(posedge clk);
        @(negedge clk);

        // Backpressure: 10 beats, out_ready low for 5 cycles mid-stream
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc < 11);
            in_valid = (sent < 10);
            x0_r = 16'(sent + 1); x0_i = '0; x1_r = '0; x1_i = '0;
            tw_r = 16'd256; tw_i = '0; scale_en = 1'b0;
            #1;
            if (cyc == 8) chk("bp_stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                chk("bp_order", $signed(f0_r), got + 1);
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", got, 10);

        // Overflow beat transfers in the same cycle as a clear: set wins
        @(posedge clk);
        send(30000, 0, 10000, 0, 256, 0, 1'b0);
        chk("sc_sticky_pre", ovf_sticky, 0);
        clr_ovf = 1'b1;
        @(posedge clk);
        #1 clr_ovf = 1'b0;
        chk("sc_sticky_setwins", ovf_sticky, 1);

        // Reset with three beats in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x0_r = 16'(k + 1); x0_i = '0; x1_r = '0; x1_i = '0;
            tw_r = 16'd256; tw_i = '0; scale_en = 1'b0;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        chk("mr_pre_valid", out_valid, 1);
        chk("mr_pre_f0_r", $signed(f0_r), 1);
        rst = 1'b1;
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_f0_r", $signed(f0_r), 0);
        chk("mr_f1_r", $signed(f1_r), 0);
        chk("mr_sticky", ovf_sticky, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_flushed", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b1;
        x0_r = 16'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_lat_early", out_valid, 0);
        @(posedge clk);
        #1;
        chk("mr_lat_valid", out_valid, 1);
        chk("mr_lat_f0_r", $signed(f0_r), 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
